// File: rtl/dev_timer_mc.sv
// dev_timer_mc: bus-mapped timer/counter with compare channels and pin outputs.
// Optional input capture is built in when TIMER_CAPTURE_EN is defined.
module dev_timer_mc #(
    parameter int TIMER_BITS = 16,
    parameter int CHANNELS   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stb,
    input  logic                we,
    input  logic [3:0]          addr,
    input  logic [31:0]         dtw,
    output logic [31:0]         dtr,
    output logic                ack,
    input  logic                io_risen,
    input  logic                io_fallen,
    output logic [CHANNELS-1:0] io_out,
    output logic [CHANNELS-1:0] io_oe,
    output logic                irq
);

    localparam int SW = CHANNELS + 2;
    localparam logic [TIMER_BITS-1:0] MAX = '1;
    localparam logic [TIMER_BITS-1:0] ONE = TIMER_BITS'(1);

    typedef enum logic [1:0] {
        MODE_FREE = 2'd0,
        MODE_CTC  = 2'd1,
        MODE_UPDN = 2'd2,
        MODE_RSVD = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_t;

    logic [2:0]            r_src;
    mode_t                 r_mode;
    logic [9:0]            r_div;
    logic [TIMER_BITS-1:0] r_cnt;
    dir_t                  r_dir;
    logic [SW-1:0]         r_status;
    logic [SW-1:0]         r_irqen;
    logic [TIMER_BITS-1:0] r_shadow [CHANNELS];
    logic [TIMER_BITS-1:0] r_active [CHANNELS];
    logic [1:0]            r_cfg    [CHANNELS];
    logic [CHANNELS-1:0]   r_out;
    logic                  r_ack;
`ifdef TIMER_CAPTURE_EN
    logic [TIMER_BITS-1:0] r_cap;
`endif

    logic                  w_wr;
    logic                  w_wr_ctrl;
    logic                  w_wr_cnt;
    logic                  w_wr_stat;
    logic                  w_wr_irqen;
    logic [2:0]            w_pair;
    logic                  w_ch_hit;
    logic [CHANNELS-1:0]   w_wr_cmp;
    logic [CHANNELS-1:0]   w_wr_cfg;
    logic                  w_tick;
    logic [CHANNELS-1:0]   w_match;
    logic                  w_ovf;
    logic [TIMER_BITS-1:0] w_cnt_nxt;
    dir_t                  w_dir_nxt;
    logic [SW-1:0]         w_set;
    logic                  w_unused;

    assign w_wr       = stb & we;
    assign w_wr_ctrl  = w_wr && (addr == 4'd0);
    assign w_wr_cnt   = w_wr && (addr == 4'd1);
    assign w_wr_stat  = w_wr && (addr == 4'd2);
    assign w_wr_irqen = w_wr && (addr == 4'd3);
    assign w_pair     = addr[3:1] - 3'd2;
    assign w_ch_hit   = (addr >= 4'd4) && (addr <= 4'd11)
                      && (w_pair < 3'(CHANNELS));
    assign w_unused   = ^dtw;

    assign ack = r_ack;
    assign irq = |(r_status & r_irqen);
    assign io_out = r_out;

    // Per-channel write strobes and output enables
    always_comb begin
        w_wr_cmp = '0;
        w_wr_cfg = '0;
        io_oe    = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_wr && w_ch_hit && (w_pair == 3'(k))) begin
                if (addr[0]) w_wr_cfg[k] = 1'b1;
                else         w_wr_cmp[k] = 1'b1;
            end
            io_oe[k] = (r_cfg[k] != 2'd0);
        end
    end

    // Tick source selection from prescaler taps or pin edges
    always_comb begin
        w_tick = 1'b0;
        unique case (r_src)
            3'd0: w_tick = 1'b0;
            3'd1: w_tick = 1'b1;
            3'd2: w_tick = &r_div[2:0];
            3'd3: w_tick = &r_div[5:0];
            3'd4: w_tick = &r_div[7:0];
            3'd5: w_tick = &r_div;
            3'd6: w_tick = io_risen;
            3'd7: w_tick = io_fallen;
        endcase
    end

    // Compare matches; a counter write suppresses the tick entirely
    always_comb begin
        w_match = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_match[k] = w_tick && !w_wr_cnt && (r_cnt == r_active[k]);
        end
    end

    // Counter/direction next state and overflow event
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir;
        w_ovf     = 1'b0;
        if (w_wr_cnt) begin
            w_cnt_nxt = dtw[TIMER_BITS-1:0];
        end else if (w_tick) begin
            case (r_mode)
                MODE_CTC: begin
                    if (r_cnt == r_active[0]) begin
                        w_cnt_nxt = '0;
                        w_ovf     = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + ONE;
                    end
                end
                MODE_UPDN: begin
                    if (r_dir == DIR_UP) begin
                        if (r_cnt == MAX) begin
                            w_dir_nxt = DIR_DN;
                            w_cnt_nxt = MAX - ONE;
                        end else begin
                            w_cnt_nxt = r_cnt + ONE;
                        end
                    end else begin
                        if (r_cnt == '0) begin
                            w_ovf     = 1'b1;
                            w_dir_nxt = DIR_UP;
                            w_cnt_nxt = ONE;
                        end else begin
                            w_cnt_nxt = r_cnt - ONE;
                        end
                    end
                end
                default: begin
                    if (r_cnt == MAX) begin
                        w_cnt_nxt = '0;
                        w_ovf     = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + ONE;
                    end
                end
            endcase
        end
    end

    // Status set sources: overflow, matches, capture
    always_comb begin
        w_set    = '0;
        w_set[0] = w_ovf;
        for (int k = 0; k < CHANNELS; k++) begin
            w_set[1+k] = w_match[k];
        end
`ifdef TIMER_CAPTURE_EN
        w_set[SW-1] = io_risen;
`endif
    end

    // Control, prescaler, counter, direction, status, irq enable, ack
    always_ff @(posedge clk) begin
        if (reset) begin
            r_src    <= 3'd0;
            r_mode   <= MODE_FREE;
            r_div    <= '0;
            r_cnt    <= '0;
            r_dir    <= DIR_UP;
            r_status <= '0;
            r_irqen  <= '0;
            r_ack    <= 1'b0;
        end else begin
            r_ack <= stb;
            r_cnt <= w_cnt_nxt;
            r_dir <= w_dir_nxt;
            if (w_wr_ctrl) begin
                r_src  <= dtw[2:0];
                r_mode <= (dtw[4:3] == 2'd3) ? MODE_FREE : mode_t'(dtw[4:3]);
                r_div  <= '0;
            end else begin
                r_div <= r_div + 10'd1;
            end
            r_status <= (r_status & ~(w_wr_stat ? dtw[SW-1:0] : '0)) | w_set;
            if (w_wr_irqen) r_irqen <= dtw[SW-1:0];
        end
    end

    // Compare shadow/active pairs and channel configuration
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < CHANNELS; k++) begin
                r_shadow[k] <= '0;
                r_active[k] <= '0;
                r_cfg[k]    <= 2'd0;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (w_wr_cmp[k]) r_shadow[k] <= dtw[TIMER_BITS-1:0];
                if (r_src == 3'd0) begin
                    r_active[k] <= w_wr_cmp[k] ? dtw[TIMER_BITS-1:0]
                                               : r_shadow[k];
                end else if (w_ovf) begin
                    r_active[k] <= r_shadow[k];
                end
                if (w_wr_cfg[k]) r_cfg[k] <= dtw[1:0];
            end
        end
    end

    // Pin output actions driven by match and overflow events
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (r_cfg[k] == 2'd0) begin
                    r_out[k] <= 1'b0;
                end else if (r_cfg[k] == 2'd1) begin
                    if (w_match[k]) r_out[k] <= ~r_out[k];
                end else if (r_mode == MODE_UPDN) begin
                    if (w_match[k]) begin
                        r_out[k] <= (r_dir == DIR_UP) ? (r_cfg[k] == 2'd2)
                                                      : (r_cfg[k] != 2'd2);
                    end
                end else if (w_match[k]) begin
                    r_out[k] <= (r_cfg[k] == 2'd2);
                end else if (w_ovf) begin
                    r_out[k] <= (r_cfg[k] != 2'd2);
                end
            end
        end
    end

`ifdef TIMER_CAPTURE_EN
    // Input capture of the counter on a rising pin edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cap <= '0;
        end else if (io_risen) begin
            r_cap <= r_cnt;
        end
    end
`endif

    // Combinational read mux
    always_comb begin
        dtr = 32'd0;
        case (addr)
            4'd0: dtr = {27'd0, r_mode, r_src};
            4'd1: dtr = 32'(r_cnt);
            4'd2: dtr = 32'(r_status);
            4'd3: dtr = 32'(r_irqen);
`ifdef TIMER_CAPTURE_EN
            4'd12: dtr = 32'(r_cap);
`endif
            default: begin
                for (int k = 0; k < CHANNELS; k++) begin
                    if (w_ch_hit && (w_pair == 3'(k))) begin
                        dtr = addr[0] ? {30'd0, r_cfg[k]} : 32'(r_shadow[k]);
                    end
                end
            end
        endcase
    end

endmodule

// File: doc/dev_timer_mc.md
DEV_TIMER_MC -- requirements
Module: dev_timer_mc

Interface
REQ-001 SHALL have parameter TIMER_BITS, default 16, counter/compare width (2..32).
REQ-002 SHALL have parameter CHANNELS, default 2, compare channel count (1..4).
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports stb input 1 bus strobe; we input 1 write enable; addr input 4 register index; dtw input 32 write data.
REQ-006 SHALL have ports dtr output 32 read data; ack output 1 transfer acknowledge.
REQ-007 SHALL have ports io_risen and io_fallen, both input 1, one-cycle edge pulses from the pin synchroniser.
REQ-008 SHALL have ports io_out and io_oe, both output CHANNELS: per-channel pin value and output enable.
REQ-009 SHALL have port irq  output  1  level interrupt, equal to OR of (STATUS & IRQEN).

Function
REQ-010 Register map SHALL be: 0 CTRL, 1 COUNTER, 2 STATUS, 3 IRQEN, 4+2k CMPk, 5+2k CHCFGk, 12 CAPTURE; unmapped addresses read 0, writes ignored.
REQ-011 CTRL SHALL hold clk_source [2:0] (0 stop, 1 clk, 2 /8, 3 /64, 4 /256, 5 /1024, 6 io_risen, 7 io_fallen) and mode [4:3] (0 free-run, 1 CTC, 2 up/down, 3 reserved as 0).
REQ-012 Prescaler SHALL be a free-running 10-bit divider, cleared by reset or any CTRL write; tick is one pulse when the low 3/6/8/10 bits are all ones.
REQ-013 Free-run: each tick increments counter; max wraps to 0 and sets STATUS.ovf.
REQ-014 CTC: tick with counter==active CMP0 loads 0 and sets ovf; otherwise increments.
REQ-015 Up/down: count up to max, then down to 0; direction flips at each end; ovf set on tick at 0 while counting down.
REQ-016 Match k SHALL occur on a tick while counter==active CMPk; it sets STATUS bit 1+k.
REQ-017 CMPk writes SHALL go to a shadow register, copied to active on the wrap/ovf tick, or immediately if clk_source==0.
REQ-018 CHCFGk[1:0] action SHALL be: 0 off (io_oe 0), 1 toggle on match, 2 PWM (set on match, clear on ovf; up/down: set on up-match, clear on down-match), 3 inverted PWM.
REQ-019 io_out SHALL update one clk after the causing tick; io_oe[k]=1 when action!=0.
REQ-020 STATUS SHALL be write-1-to-clear; a same-cycle hardware set SHALL win over clear.
REQ-021 A COUNTER write SHALL load dtw[TIMER_BITS-1:0] and win over a same-cycle tick; it SHALL not generate match or ovf.
REQ-022 ack SHALL assert for exactly one cycle, the cycle after stb; dtr SHALL be combinational from addr; reads SHALL have no side effects.

Reset
REQ-023 Reset SHALL zero all registers, divider, shadows, io_out, io_oe, ack and irq; direction SHALL reset to up.
REQ-024 Reset mid-count SHALL take priority over every bus and tick event in that cycle.

Configuration
REQ-025 Macro TIMER_CAPTURE_EN defined: io_risen SHALL latch counter into CAPTURE and set STATUS bit 1+CHANNELS; a set on the same cycle as a capture SHALL take the new value.
REQ-026 Macro TIMER_CAPTURE_EN undefined: CAPTURE and its status bit SHALL read 0; clk_source 6 SHALL still work.

Verification
REQ-027 CTRL=clk, free-run, TIMER_BITS=16 -> counter wraps 0xFFFF->0 after 65536 ticks; STATUS=0x1; irq=1 only with IRQEN bit0=1.
REQ-028 CTC, CMP0=9, CHCFG0=toggle -> counter period 10 clk; io_out[0] toggles every 10 clk.
REQ-029 Up/down, CMP1=0x8000, CHCFG1=PWM -> io_out[1] high on up-crossing 0x8000, low on down-crossing; one ovf per 131070 ticks.
REQ-030 Write CMP0=5 mid-period, then W1C STATUS while an ovf lands -> active CMP0 changes only at the wrap; ovf bit stays 1.
REQ-031 TIMER_CAPTURE_EN, counter=0x1234 on an io_risen pulse -> CAPTURE=0x1234, STATUS bit 3 set (CHANNELS=2); reset asserted -> all reads 0.
